// File: rtl/alu_fitness_monitor.sv
// Coverage-feedback monitor: records OP/operand-class bins over a window of accepted ALU
// transfers and reports the distinct-bin count. Define FITNESS_OPB_BINS_EN to add operand-B class bins.
module alu_fitness_monitor #(
  parameter int DATA_WIDTH  = 8,
  parameter int TRANS_COUNT = 100
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  ALU_ACT,
  input  logic                  ALU_RDY,
  input  logic [3:0]            OP,
  input  logic [1:0]            MOVI,
  input  logic [DATA_WIDTH-1:0] REG_A,
  input  logic [DATA_WIDTH-1:0] REG_B,
  input  logic [DATA_WIDTH-1:0] MEM,
  input  logic [DATA_WIDTH-1:0] IMM,
  output logic                  BUSY,
  output logic                  FIT_VLD,
  input  logic                  FIT_ACK,
  output logic [7:0]            FITNESS,
  output logic [15:0]           ILLEGAL_CNT
);

`ifdef FITNESS_OPB_BINS_EN
  localparam int NBINS = 144;
`else
  localparam int NBINS = 96;
`endif
  localparam int CNT_W = (TRANS_COUNT < 2) ? 1 : $clog2(TRANS_COUNT + 1);
  localparam int IDX_W = $clog2(NBINS);
  localparam logic [NBINS-1:0] ONE_HOT0 = NBINS'(1);

  typedef enum logic [1:0] {IDLE, RUN, COUNT, REPORT} state_t;

  state_t           state;
  logic [NBINS-1:0] bitmap;
  logic [NBINS-1:0] hits;
  logic [NBINS-1:0] scan_vec;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] scan_idx;
  logic             bit_p0;
  logic             last_p0;
  logic             vld_p0;
  logic             xfer;

  // Operand class: 0 = zero, 1 = all-ones, 2 = anything else
  function automatic logic [7:0] op_class(input logic [DATA_WIDTH-1:0] v);
    if (v == '0)      return 8'd0;
    else if (&v)      return 8'd1;
    else              return 8'd2;
  endfunction

  function automatic logic [7:0] bin_base(input logic [3:0] op);
    return {4'b0, op} * 8'd3;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] opb_sel(input logic [1:0] movi,
                                                    input logic [DATA_WIDTH-1:0] rb,
                                                    input logic [DATA_WIDTH-1:0] mem,
                                                    input logic [DATA_WIDTH-1:0] imm);
    case (movi)
      2'b00:   return rb;
      2'b01:   return mem;
      default: return imm;
    endcase
  endfunction

  assign xfer     = ALU_ACT && ALU_RDY;
  assign scan_vec = bitmap >> scan_idx;

  // Bins touched by the transfer currently on the bus
  always_comb begin
    hits = '0;
    if (MOVI != 2'b11)
      hits = hits | (ONE_HOT0 << (bin_base(OP) + {6'b0, MOVI}));
    hits = hits | (ONE_HOT0 << (8'd48 + bin_base(OP) + op_class(REG_A)));
`ifdef FITNESS_OPB_BINS_EN
    if (MOVI != 2'b11)
      hits = hits | (ONE_HOT0 << (8'd96 + bin_base(OP) + op_class(opb_sel(MOVI, REG_B, MEM, IMM))));
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      BUSY        <= 1'b0;
      FIT_VLD     <= 1'b0;
      FITNESS     <= '0;
      ILLEGAL_CNT <= '0;
      bitmap      <= '0;
      cnt         <= '0;
      scan_idx    <= '0;
      bit_p0      <= 1'b0;
      last_p0     <= 1'b0;
      vld_p0      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state       <= RUN;
            BUSY        <= 1'b1;
            bitmap      <= '0;
            cnt         <= '0;
            ILLEGAL_CNT <= '0;
            FITNESS     <= '0;
            scan_idx    <= '0;
            vld_p0      <= 1'b0;
          end
        end
        RUN: begin
          if (xfer) begin
            bitmap <= bitmap | hits;
            cnt    <= cnt + 1'b1;
            if (MOVI == 2'b11 && ILLEGAL_CNT != 16'hFFFF)
              ILLEGAL_CNT <= ILLEGAL_CNT + 16'd1;
            if (cnt == CNT_W'(TRANS_COUNT - 1))
              state <= COUNT;
          end
        end
        COUNT: begin
          // p0: sample one bitmap bit per cycle; p1: accumulate into FITNESS
          if (vld_p0 && last_p0) begin
            state   <= REPORT;
            FIT_VLD <= 1'b1;
            vld_p0  <= 1'b0;
          end else begin
            bit_p0   <= scan_vec[0];
            last_p0  <= (scan_idx == IDX_W'(NBINS - 1));
            vld_p0   <= 1'b1;
            scan_idx <= scan_idx + 1'b1;
          end
          if (vld_p0)
            FITNESS <= FITNESS + {7'b0, bit_p0};
        end
        REPORT: begin
          if (FIT_ACK) begin
            state   <= IDLE;
            FIT_VLD <= 1'b0;
            BUSY    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_fitness_monitor.sv
// Directed bench for alu_fitness_monitor (TRANS_COUNT=4) with a fitness scoreboard
// popped by an independent monitor on each FIT_VLD rise.
module tb_alu_fitness_monitor;

`ifdef FITNESS_OPB_BINS_EN
  localparam int NB = 144;
  localparam int C  = 1;
`else
  localparam int NB = 96;
  localparam int C  = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ALU_ACT = 1'b0;
  logic       ALU_RDY = 1'b0;
  logic [3:0] OP = '0;
  logic [1:0] MOVI = '0;
  logic [7:0] REG_A = '0, REG_B = '0, MEM = '0, IMM = '0;
  logic       BUSY, FIT_VLD;
  logic       FIT_ACK = 1'b0;
  logic [7:0] FITNESS;
  logic [15:0] ILLEGAL_CNT;

  int errors = 0;
  int checks = 0;
  int exp_fit_q[$];
  int exp_ill_q[$];
  logic vld_q = 1'b0;

  alu_fitness_monitor #(.DATA_WIDTH(8), .TRANS_COUNT(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ALU_ACT(ALU_ACT), .ALU_RDY(ALU_RDY),
    .OP(OP), .MOVI(MOVI), .REG_A(REG_A), .REG_B(REG_B), .MEM(MEM), .IMM(IMM),
    .BUSY(BUSY), .FIT_VLD(FIT_VLD), .FIT_ACK(FIT_ACK), .FITNESS(FITNESS),
    .ILLEGAL_CNT(ILLEGAL_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare the reported fitness against the oldest expectation
  always @(negedge CLK) begin
    if (FIT_VLD && !vld_q) begin
      if (exp_fit_q.size() == 0) begin
        chk("unexpected_report", 1, 0);
      end else begin
        chk("sb_fitness", int'(FITNESS), exp_fit_q.pop_front());
        chk("sb_illegal", int'(ILLEGAL_CNT), exp_ill_q.pop_front());
      end
    end
    vld_q = FIT_VLD;
  end

  task automatic start_win();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("busy_after_start", int'(BUSY), 1);
  endtask

  task automatic xfer(input logic [3:0] op, input logic [1:0] mv, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] m, input logic [7:0] i,
                      input int stall);
    OP = op; MOVI = mv; REG_A = a; REG_B = b; MEM = m; IMM = i;
    ALU_ACT = 1'b1;
    ALU_RDY = 1'b0;
    repeat (stall) begin @(posedge CLK); #1; end
    ALU_RDY = 1'b1;
    @(posedge CLK); #1;
    ALU_ACT = 1'b0;
    ALU_RDY = 1'b0;
  endtask

  task automatic wait_report(input string name);
    int n = 0;
    while (!FIT_VLD && n < 400) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(name, n, NB + 1);
  endtask

  task automatic ack();
    FIT_ACK = 1'b1;
    @(posedge CLK); #1;
    FIT_ACK = 1'b0;
    chk("busy_after_ack", int'(BUSY), 0);
    chk("vld_after_ack", int'(FIT_VLD), 0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_vld", int'(FIT_VLD), 0);
    chk("rst_fitness", int'(FITNESS), 0);
    chk("rst_illegal", int'(ILLEGAL_CNT), 0);

    // W1: OP0/MOVI00/A=0 x4 -> A bin 0, B bin 48; REG_B=0x12 adds one C bin
    exp_fit_q.push_back(2 + C); exp_ill_q.push_back(0);
    start_win();
    for (int k = 0; k < 4; k++) xfer(4'd0, 2'b00, 8'h00, 8'h12, 8'h00, 8'h00, 0);
    wait_report("latency_w1");
    ack();
    @(posedge CLK); #1;
    chk("fitness_held_idle", int'(FITNESS), 2 + C);

    // W2: OP1..4, MOVI01, A=FF, MEM=FF, stalled 2 cycles each -> 4 A + 4 B (+4 C)
    exp_fit_q.push_back(8 + 4 * C); exp_ill_q.push_back(0);
    start_win();
    for (int k = 1; k <= 4; k++) xfer(4'(k), 2'b01, 8'hFF, 8'h00, 8'hFF, 8'h00, 2);
    wait_report("latency_w2");
    ack();

    // W3: illegal OP5 (1 B bin), OP6 MOVI00 A=0 twice (2 bins), OP7 MOVI10 A=1 IMM=FF (2 bins)
    exp_fit_q.push_back(5 + 2 * C); exp_ill_q.push_back(1);
    start_win();
    xfer(4'd5, 2'b11, 8'h07, 8'h00, 8'h00, 8'h00, 0);
    xfer(4'd6, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    xfer(4'd6, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    xfer(4'd7, 2'b10, 8'h01, 8'h00, 8'h00, 8'hFF, 0);
    wait_report("latency_w3");

    // Hold in REPORT with START and transfers active: nothing may change
    START = 1'b1; ALU_ACT = 1'b1; ALU_RDY = 1'b1;
    OP = 4'd15; MOVI = 2'b11; REG_A = 8'h00;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK); #1;
      chk("hold_vld", int'(FIT_VLD), 1);
      chk("hold_fitness", int'(FITNESS), 5 + 2 * C);
      chk("hold_illegal", int'(ILLEGAL_CNT), 1);
      chk("hold_busy", int'(BUSY), 1);
    end
    FIT_ACK = 1'b1;
    @(posedge CLK); #1;
    FIT_ACK = 1'b0; START = 1'b0; ALU_ACT = 1'b0; ALU_RDY = 1'b0;
    chk("ack_start_busy", int'(BUSY), 0);
    chk("ack_start_vld", int'(FIT_VLD), 0);
    @(posedge CLK); #1;
    chk("idle_after_ack_start", int'(BUSY), 0);

    // W4: reset after 2 transfers, then a fresh window OP10/A=B=0x33 -> 2 bins (+1 C)
    start_win();
    xfer(4'd9, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    xfer(4'd9, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("midrst_busy", int'(BUSY), 0);
    chk("midrst_vld", int'(FIT_VLD), 0);
    chk("midrst_fitness", int'(FITNESS), 0);
    chk("midrst_illegal", int'(ILLEGAL_CNT), 0);
    exp_fit_q.push_back(2 + C); exp_ill_q.push_back(0);
    start_win();
    for (int k = 0; k < 4; k++) xfer(4'd10, 2'b00, 8'h33, 8'h33, 8'h00, 8'h00, 0);
    wait_report("latency_w4");
    ack();

    repeat (3) @(posedge CLK);
    #1 chk("sb_drained", exp_fit_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
